writeback_stage: RTL and testbench
==================================

# writeback_stage

Final (MEM/WB) pipeline stage of the RISC-V CPU: registers the memory-stage result, selects the write-back source, aligns and sign/zero-extends load data, and drives the register file write port (AD3/WD3/WE3). It also provides forwarding data to the execute stage and keeps a retired-instruction counter. It sits directly upstream of register_file, between data memory and the register file write port.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- ADDRESS_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hold stage contents
- flush_i  in  1  insert bubble on next edge
- valid_i  in  1  incoming instruction valid
- reg_write_i  in  1  instruction writes rd
- rd_i  in  ADDRESS_WIDTH  destination register
- result_src_i  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- funct3_i  in  3  load size/sign
- addr_lsb_i  in  2  low bits of load address
- alu_result_i  in  DATA_WIDTH  ALU result
- read_data_i  in  DATA_WIDTH  raw data-memory word (combinational read, same cycle as other inputs)
- pc_plus4_i  in  DATA_WIDTH  return address
- AD3_o  out  ADDRESS_WIDTH  register file write address
- WD3_o  out  DATA_WIDTH  register file write data
- WE3_o  out  1  register file write enable
- fwd_valid_o  out  1  forwarding data valid (= WE3_o)
- instret_o  out  32  retired-instruction count

## Operation
- Input mux (combinational, before the register): result = ALU / extended load / PC+4 per result_src_i.
- Load extension, per funct3_i:
  - 000 LB: byte addr_lsb_i, sign-extended
  - 001 LH: half addr_lsb_i[1], sign-extended; addr_lsb_i[0] ignored
  - 010 LW: full word; addr_lsb_i ignored
  - 100 LBU: byte, zero-extended
  - 101 LHU: half, zero-extended
  - 011/110/111: treated as LW
- Stage register holds valid_q, we_q, rd_q, result_q.
- Register update priority on the clock edge: rst (async) > flush_i > stall_i > capture.
  - flush_i: valid_q <= 0. Flush wins over stall.
  - stall_i: hold all.
  - Otherwise capture valid_i, reg_write_i, rd_i, result.
- Outputs:
  - WE3_o = valid_q & we_q & (rd_q != 0). Writes to x0 are always suppressed.
  - AD3_o = rd_q, WD3_o = result_q.
  - While stalled, the same write repeats each cycle; this is idempotent.
- instret_o increments by 1 on an edge where valid_q=1 and stall_i=0, including when flush_i=1 (the flush kills the incoming instruction, not the resident one). The counter wraps 0xFFFFFFFF -> 0.

## Timing
- Latency: 1 cycle from input capture to WE3_o/WD3_o. The register file commits on the following edge.
- Reset (async, immediate): valid_q=0, we_q=0, rd_q=0, result_q=0, instret_o=0. Consequently WE3_o=0, AD3_o=0, WD3_o=0, fwd_valid_o=0.
- Reset asserted mid-stall or mid-flush: everything clears. The first capture happens on the first edge after rst deasserts.
- Simultaneous stall_i=1 and flush_i=1: bubble inserted; the resident instruction is not counted (stall_i=1).

## Structure
- Shared package cpu_pkg holds:
  - result_src_t enum (RES_ALU, RES_LOAD, RES_PC4)
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
- Sub-module load_extender: purely combinational (read_data, addr_lsb, funct3 -> extended word). Instantiated once.
- Remainder: one always_ff with async reset for the stage register and counter, plus one always_comb for the mux.

## Test plan
- Reset then ALU write: valid_i=1, reg_write_i=1, rd_i=10, result_src=00, alu=0x1234 -> next cycle WE3_o=1, AD3_o=10, WD3_o=0x1234; instret_o=1 one edge later.
- Load extension: read_data=0x80FF7F01.
  - LB lsb=2 -> 0xFFFFFFFF
  - LBU lsb=3 -> 0x00000080
  - LH lsb=2 -> 0xFFFF80FF
  - LHU lsb=0 -> 0x00007F01
  - LW -> 0x80FF7F01
- x0 suppression: rd_i=0, reg_write_i=1, alu=0xDEAD -> WE3_o=0 while WD3_o=0xDEAD; instret_o still increments.
- Stall then flush: capture rd=5; stall 3 cycles -> WE3_o held at 1, instret unchanged; then stall=1 with flush=1 -> valid drops, instret unchanged.
- Async reset mid-operation: instret=7, valid_q=1; rst pulse between edges -> WE3_o=0 and instret_o=0 immediately, before any clock edge.
- Counter wrap: preload instret to 0xFFFFFFFF via 2^32-1 retires (or a force in the bench) -> next retire gives 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back source select and load funct3 encodings.
package cpu_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module load_extender
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic [1:0]            addr_lsb,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Byte lane follows both address bits; half lane ignores addr_lsb[0].
   always_comb begin
      byte_sel  = read_data[{addr_lsb, 3'b000} +: 8];
      half_sel  = read_data[{addr_lsb[1], 4'b0000} +: 16];
      load_data = read_data;
      case (funct3)
         F3_LB:   load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_data = read_data; // LW and unused encodings
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: result select, stage register, register-file write port and retire counter.
module writeback_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   input  logic                     reg_write_i,
   input  logic [ADDRESS_WIDTH-1:0] rd_i,
   input  logic [1:0]               result_src_i,
   input  logic [2:0]               funct3_i,
   input  logic [1:0]               addr_lsb_i,
   input  logic [DATA_WIDTH-1:0]    alu_result_i,
   input  logic [DATA_WIDTH-1:0]    read_data_i,
   input  logic [DATA_WIDTH-1:0]    pc_plus4_i,
   output logic [ADDRESS_WIDTH-1:0] AD3_o,
   output logic [DATA_WIDTH-1:0]    WD3_o,
   output logic                     WE3_o,
   output logic                     fwd_valid_o,
   output logic [31:0]              instret_o
);

   logic                     valid_q;
   logic                     we_q;
   logic [ADDRESS_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0]    result_q;
   logic [DATA_WIDTH-1:0]    result_d;
   logic [DATA_WIDTH-1:0]    load_data;
   logic [31:0]              instret_q;

   load_extender #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_load_extender (
      .read_data(read_data_i),
      .addr_lsb (addr_lsb_i),
      .funct3   (funct3_i),
      .load_data(load_data)
   );

   // Write-back source mux; the reserved encoding falls back to the ALU result.
   always_comb begin
      result_d = alu_result_i;
      case (result_src_t'(result_src_i))
         RES_LOAD: result_d = load_data;
         RES_PC4:  result_d = pc_plus4_i;
         default:  result_d = alu_result_i;
      endcase
   end

   // Stage register and retire counter; flush beats stall, and the resident
   // instruction retires whenever the stage is not stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
         rd_q      <= '0;
         result_q  <= '0;
         instret_q <= '0;
      end else begin
         if (valid_q && !stall_i) begin
            instret_q <= instret_q + 32'd1;
         end
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (!stall_i) begin
            valid_q  <= valid_i;
            we_q     <= reg_write_i;
            rd_q     <= rd_i;
            result_q <= result_d;
         end
      end
   end

   assign WE3_o       = valid_q & we_q & (rd_q != '0);
   assign AD3_o       = rd_q;
   assign WD3_o       = result_q;
   assign fwd_valid_o = WE3_o;
   assign instret_o   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized traffic
// compared against a behavioural model of the stage.
module tb_writeback_stage;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic        valid_i;
   logic        reg_write_i;
   logic [4:0]  rd_i;
   logic [1:0]  result_src_i;
   logic [2:0]  funct3_i;
   logic [1:0]  addr_lsb_i;
   logic [31:0] alu_result_i;
   logic [31:0] read_data_i;
   logic [31:0] pc_plus4_i;
   logic [4:0]  AD3_o;
   logic [31:0] WD3_o;
   logic        WE3_o;
   logic        fwd_valid_o;
   logic [31:0] instret_o;

   int checks;
   int failures;

   // Behavioural model state.
   bit          m_valid;
   bit          m_we;
   int unsigned m_rd;
   int unsigned m_result;
   int unsigned m_instret;

   writeback_stage #(
      .DATA_WIDTH   (32),
      .ADDRESS_WIDTH(5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .reg_write_i (reg_write_i),
      .rd_i        (rd_i),
      .result_src_i(result_src_i),
      .funct3_i    (funct3_i),
      .addr_lsb_i  (addr_lsb_i),
      .alu_result_i(alu_result_i),
      .read_data_i (read_data_i),
      .pc_plus4_i  (pc_plus4_i),
      .AD3_o       (AD3_o),
      .WD3_o       (WD3_o),
      .WE3_o       (WE3_o),
      .fwd_valid_o (fwd_valid_o),
      .instret_o   (instret_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Load value derived arithmetically from the byte/half rules.
   function automatic int unsigned ref_load(int unsigned word, int unsigned lsb, int unsigned f3);
      int unsigned b;
      int unsigned h;
      b = (word / (1 << (8 * lsb))) % 256;
      h = (word / (1 << (16 * (lsb / 2)))) % 65536;
      case (f3)
         0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         4:       return b;
         5:       return h;
         default: return word;
      endcase
   endfunction

   function automatic int unsigned ref_result();
      case (result_src_i)
         2'b01:   return ref_load(read_data_i, addr_lsb_i, funct3_i);
         2'b10:   return pc_plus4_i;
         default: return alu_result_i;
      endcase
   endfunction

   task automatic model_reset();
      m_valid   = 0;
      m_we      = 0;
      m_rd      = 0;
      m_result  = 0;
      m_instret = 0;
   endtask

   task automatic check_all(input string tag);
      bit exp_we;
      exp_we = m_valid && m_we && (m_rd != 0);
      check_eq({tag, ".we3"}, {31'd0, WE3_o}, {31'd0, exp_we});
      check_eq({tag, ".fwd"}, {31'd0, fwd_valid_o}, {31'd0, exp_we});
      check_eq({tag, ".ad3"}, {27'd0, AD3_o}, m_rd);
      check_eq({tag, ".wd3"}, WD3_o, m_result);
      check_eq({tag, ".instret"}, instret_o, m_instret);
   endtask

   task automatic drive(input bit v, input bit rw, input int unsigned rd, input int unsigned src,
                        input int unsigned f3, input int unsigned lsb, input int unsigned alu,
                        input int unsigned rdata, input int unsigned pc4);
      valid_i      = v;
      reg_write_i  = rw;
      rd_i         = rd[4:0];
      result_src_i = src[1:0];
      funct3_i     = f3[2:0];
      addr_lsb_i   = lsb[1:0];
      alu_result_i = alu;
      read_data_i  = rdata;
      pc_plus4_i   = pc4;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      stall_i = 0;
      flush_i = 0;
   endtask

   // One clock: advance the model on the rising edge, check on the falling edge.
   task automatic step(input string tag);
      int unsigned res;
      @(posedge clk);
      res = ref_result();
      if (m_valid && !stall_i) m_instret = m_instret + 1;
      if (flush_i) begin
         m_valid = 0;
      end else if (!stall_i) begin
         m_valid  = valid_i;
         m_we     = reg_write_i;
         m_rd     = rd_i;
         m_result = res;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic reset_pulse();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_eq("rst.we3", {31'd0, WE3_o}, 32'd0);
      check_eq("rst.instret", instret_o, 32'd0);
      check_all("rst");
      rst = 1'b0;
      #1;
   endtask

   int unsigned ld_f3  [5] = '{0, 4, 1, 5, 2};
   int unsigned ld_lsb [5] = '{2, 3, 2, 0, 1};
   int unsigned ld_exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01};

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle();
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // ALU write, then retire count one edge later.
      drive(1, 1, 10, 0, 0, 0, 32'h1234, 0, 0);
      step("alu");
      check_eq("alu.we3", {31'd0, WE3_o}, 32'd1);
      check_eq("alu.ad3", {27'd0, AD3_o}, 32'd10);
      check_eq("alu.wd3", WD3_o, 32'h1234);
      idle();
      step("alu_ret");
      check_eq("alu.instret", instret_o, 32'd1);

      // Load extension cases.
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 3, 1, ld_f3[i], ld_lsb[i], 32'h5555_5555, 32'h80FF_7F01, 0);
         step("load");
         check_eq($sformatf("load%0d.wd3", i), WD3_o, ld_exp[i]);
      end

      // x0 write suppressed but still retires.
      drive(1, 1, 0, 0, 0, 0, 32'hDEAD, 0, 0);
      step("x0");
      check_eq("x0.we3", {31'd0, WE3_o}, 32'd0);
      check_eq("x0.wd3", WD3_o, 32'hDEAD);
      idle();
      step("x0_ret");

      // Stall holds the write; stall+flush drops it uncounted.
      drive(1, 1, 5, 2, 0, 0, 0, 0, 32'h100);
      step("cap5");
      stall_i = 1;
      drive(1, 1, 7, 0, 0, 0, 32'hBEEF, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("stall");
         check_eq("stall.we3", {31'd0, WE3_o}, 32'd1);
         check_eq("stall.ad3", {27'd0, AD3_o}, 32'd5);
      end
      flush_i = 1;
      step("stall_flush");
      check_eq("stflush.we3", {31'd0, WE3_o}, 32'd0);
      idle();
      step("post_flush");

      // Async reset with instret=7 and a resident instruction.
      reset_pulse();
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, i + 1, 0, 0, 0, i, 0, 0);
         step("fill");
      end
      check_eq("fill.instret", instret_o, 32'd7);
      reset_pulse();
      idle();
      @(negedge clk);
      check_all("after_rst");

      // Counter wrap.
      drive(1, 1, 9, 0, 0, 0, 32'h9, 0, 0);
      step("pre_wrap");
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 32'hFFFF_FFFF;
      check_eq("wrap.pre", instret_o, 32'hFFFF_FFFF);
      idle();
      step("wrap");
      check_eq("wrap.zero", instret_o, 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
               $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3), $urandom(),
               $urandom(), $urandom());
         stall_i = ($urandom_range(0, 3) == 0);
         flush_i = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0) begin
            reset_pulse();
         end else begin
            step("rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global timeout guard.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
